// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, instruction field positions, FSM states.
// ALU_SEQ_LOAD_EN turns opcode 100 into LOAD (R[xx] <= data_in).
package alu_seq_pkg;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 4;
    localparam int XX_MSB  = 3;
    localparam int XX_LSB  = 2;
    localparam int YY_MSB  = 1;
    localparam int YY_LSB  = 0;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_ADD   = 3'b110;
    localparam logic [2:0] OP_COPY  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Opcodes whose result lands in R[xx].
    function automatic logic writes_reg(input logic [2:0] op);
        case (op)
            OP_SET, OP_INC, OP_DEC, OP_ADD, OP_COPY: writes_reg = 1'b1;
`ifdef ALU_SEQ_LOAD_EN
            OP_LOAD:                                 writes_reg = 1'b1;
`endif
            default:                                 writes_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_reg_file.sv
// Four-entry register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear.
module seq_reg_file
    import alu_seq_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      i_ra_addr,
    output logic [SIZE-1:0] o_ra_data,
    input  logic [1:0]      i_rb_addr,
    output logic [SIZE-1:0] o_rb_data,
    input  logic            i_we,
    input  logic [1:0]      i_wa,
    input  logic [SIZE-1:0] i_wd
);

    logic [SIZE-1:0] r_reg [4];

    assign o_ra_data = r_reg[i_ra_addr];
    assign o_rb_data = r_reg[i_rb_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_reg[i] <= '0;
        end else if (i_we) begin
            r_reg[i_wa] <= i_wd;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer (IDLE -> READ -> WB) driving an external ALU.
// ALU_SEQ_LOAD_EN enables opcode 100 as LOAD from data_in; otherwise it is a no-op.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [SIZE-1:0] data_in,
    output logic [SIZE-1:0] M1,
    output logic [SIZE-1:0] M0,
    output logic [SIZE-2:0] alu_opcode,
    input  logic [SIZE-1:0] F4,
    input  logic            zero_flag,
    output logic [SIZE-1:0] data_out,
    output logic            data_out_valid,
    output logic            z_flag,
    output logic            busy
);

    state_t          r_state;
    logic [2:0]      r_op;
    logic [1:0]      r_xx;
    logic [1:0]      r_yy;
    logic            r_ready;
    logic            r_busy;
    logic [SIZE-1:0] r_m1;
    logic [SIZE-1:0] r_m0;
    logic [SIZE-2:0] r_aop;
    logic [SIZE-1:0] r_dout;
    logic            r_dov;
    logic            r_z;

    logic [SIZE-1:0] w_rd_a;
    logic [SIZE-1:0] w_rd_b;
    logic            w_we;
    logic [SIZE-1:0] w_wd;

    // Register write happens on the same edge that leaves WB.
    assign w_we = (r_state == ST_WB) && writes_reg(r_op);
`ifdef ALU_SEQ_LOAD_EN
    assign w_wd = (r_op == OP_LOAD) ? data_in : F4;
`else
    logic w_unused_data_in;
    assign w_unused_data_in = ^data_in;
    assign w_wd = F4;
`endif

    seq_reg_file #(.SIZE(SIZE)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ra_addr (r_xx),
        .o_ra_data (w_rd_a),
        .i_rb_addr (r_yy),
        .o_rb_data (w_rd_b),
        .i_we      (w_we),
        .i_wa      (r_xx),
        .i_wd      (w_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_xx    <= '0;
            r_yy    <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_m1    <= '0;
            r_m0    <= '0;
            r_aop   <= '0;
            r_dout  <= '0;
            r_dov   <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_dov <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_op    <= instr[OPC_MSB:OPC_LSB];
                        r_xx    <= instr[XX_MSB:XX_LSB];
                        r_yy    <= instr[YY_MSB:YY_LSB];
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_m1    <= w_rd_a;
                    r_m0    <= w_rd_b;
                    r_aop   <= (SIZE-1)'(r_op);
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    case (r_op)
                        OP_STORE: begin
                            r_dout <= F4;
                            r_dov  <= 1'b1;
                            r_z    <= zero_flag;
                        end
                        OP_SET, OP_INC, OP_DEC, OP_ADD, OP_COPY: r_z <= zero_flag;
`ifdef ALU_SEQ_LOAD_EN
                        OP_LOAD: r_z <= (data_in == '0);
`endif
                        default: ;
                    endcase
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready    = r_ready;
    assign busy           = r_busy;
    assign M1             = r_m1;
    assign M0             = r_m0;
    assign alu_opcode     = r_aop;
    assign data_out       = r_dout;
    assign data_out_valid = r_dov;
    assign z_flag         = r_z;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU in the loop.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [6:0]      instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [SIZE-1:0] data_in;
    logic [SIZE-1:0] M1, M0;
    logic [SIZE-2:0] alu_opcode;
    logic [SIZE-1:0] F4;
    logic            zero_flag;
    logic [SIZE-1:0] data_out;
    logic            data_out_valid;
    logic            z_flag;
    logic            busy;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int acc_q[$];

    alu_sequencer #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .data_in(data_in), .M1(M1), .M0(M0),
        .alu_opcode(alu_opcode), .F4(F4), .zero_flag(zero_flag),
        .data_out(data_out), .data_out_valid(data_out_valid), .z_flag(z_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // External ALU; NOP/LOAD produce a non-zero junk value so stray writes show up.
    always_comb begin
        case (alu_opcode)
            OP_SET:   F4 = 4'd1;
            OP_INC:   F4 = M1 + 4'd1;
            OP_DEC:   F4 = M1 - 4'd1;
            OP_ADD:   F4 = M1 + M0;
            OP_COPY:  F4 = M0;
            OP_STORE: F4 = M1;
            default:  F4 = 4'hA;
        endcase
        zero_flag = (F4 == 4'd0);
    end

    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) acc_q.push_back(cyc);
        cyc++;
    end

    // Issue one instruction; returns 1 time unit after the t+2 edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] x, input logic [1:0] y);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        vec++;
        if (instr_ready !== 1'b1) begin errs++; $display("FAIL issue_ready ready=%b want 1", instr_ready); end
        instr = {op, x, y};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 7'h7f;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (M1 !== 4'd0 || M0 !== 4'd0) begin errs++; $display("FAIL rst_operands M1=%0d M0=%0d want 0 0", M1, M0); end
        vec++; if (alu_opcode !== 3'd0) begin errs++; $display("FAIL rst_aluop got=%0d want 0", alu_opcode); end
        vec++; if (data_out !== 4'd0 || data_out_valid !== 1'b0 || z_flag !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL rst_outs dout=%0d dov=%b z=%b busy=%b want 0 0 0 0", data_out, data_out_valid, z_flag, busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vec++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready ready=%b want 1", instr_ready); end
    endtask

    task automatic test_set();
        issue(OP_SET, 2'd0, 2'd0);
        vec++; if (dut.u_rf.r_reg[0] !== 4'd1) begin errs++; $display("FAIL set_r0 R0=%0d want 1", dut.u_rf.r_reg[0]); end
        vec++; if (z_flag !== 1'b0) begin errs++; $display("FAIL set_z z=%b want 0", z_flag); end
        vec++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL set_ready ready=%b busy=%b want 1 0", instr_ready, busy); end
        vec++; if (alu_opcode !== OP_SET) begin errs++; $display("FAIL set_aluop got=%0d want 1", alu_opcode); end
    endtask

    task automatic test_add_wrap();
        issue(OP_SET, 2'd1, 2'd0);
        issue(OP_DEC, 2'd1, 2'd1);
        vec++; if (dut.u_rf.r_reg[1] !== 4'd0 || z_flag !== 1'b1) begin errs++; $display("FAIL dec_to_zero R1=%0d z=%b want 0 1", dut.u_rf.r_reg[1], z_flag); end
        issue(OP_DEC, 2'd1, 2'd1);
        vec++; if (dut.u_rf.r_reg[1] !== 4'd15) begin errs++; $display("FAIL dec_wrap R1=%0d want 15", dut.u_rf.r_reg[1]); end
        issue(OP_ADD, 2'd1, 2'd0);
        vec++; if (dut.u_rf.r_reg[1] !== 4'd0) begin errs++; $display("FAIL add_wrap R1=%0d want 0", dut.u_rf.r_reg[1]); end
        vec++; if (z_flag !== 1'b1) begin errs++; $display("FAIL add_z z=%b want 1", z_flag); end
        issue(OP_NOP, 2'd1, 2'd0);
        vec++; if (dut.u_rf.r_reg[1] !== 4'd0 || z_flag !== 1'b1) begin errs++; $display("FAIL nop_hold R1=%0d z=%b want 0 1", dut.u_rf.r_reg[1], z_flag); end
    endtask

    task automatic test_store();
        issue(OP_DEC, 2'd2, 2'd2);
        vec++; if (dut.u_rf.r_reg[2] !== 4'd15) begin errs++; $display("FAIL dec_r2 R2=%0d want 15", dut.u_rf.r_reg[2]); end
        vec++; if (data_out_valid !== 1'b0) begin errs++; $display("FAIL dov_idle dov=%b want 0", data_out_valid); end
        issue(OP_STORE, 2'd2, 2'd2);
        vec++; if (data_out !== 4'd15 || data_out_valid !== 1'b1) begin errs++; $display("FAIL store dout=%0d dov=%b want 15 1", data_out, data_out_valid); end
        vec++; if (z_flag !== 1'b0 || dut.u_rf.r_reg[2] !== 4'd15) begin errs++; $display("FAIL store_side z=%b R2=%0d want 0 15", z_flag, dut.u_rf.r_reg[2]); end
        @(posedge clk); #1;
        vec++; if (data_out_valid !== 1'b0 || data_out !== 4'd15) begin errs++; $display("FAIL store_pulse dov=%b dout=%0d want 0 15", data_out_valid, data_out); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] prog [8];
        prog[0] = {OP_SET, 2'd1, 2'd1};
        for (int i = 1; i < 7; i++) prog[i] = {OP_INC, 2'd1, 2'd1};
        prog[7] = {OP_COPY, 2'd3, 2'd1};
        acc_q.delete();
        @(negedge clk);
        instr = prog[0];
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (acc_q.size() <= i && n < 12) begin @(negedge clk); n++; end
            if (i < 7) instr = prog[i+1];
            else instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        vec++; if (acc_q.size() !== 8) begin errs++; $display("FAIL b2b_count got=%0d want 8", acc_q.size()); end
        for (int i = 1; i < acc_q.size(); i++) begin
            vec++; if (acc_q[i] - acc_q[i-1] !== 3) begin errs++; $display("FAIL b2b_spacing idx=%0d gap=%0d want 3", i, acc_q[i] - acc_q[i-1]); end
        end
        vec++; if (dut.u_rf.r_reg[3] !== 4'd7) begin errs++; $display("FAIL copy_r3 R3=%0d want 7", dut.u_rf.r_reg[3]); end
        vec++; if (dut.u_rf.r_reg[1] !== 4'd7) begin errs++; $display("FAIL copy_r1 R1=%0d want 7", dut.u_rf.r_reg[1]); end
        vec++; if (M0 !== 4'd7 || alu_opcode !== OP_COPY) begin errs++; $display("FAIL copy_ops M0=%0d op=%0d want 7 7", M0, alu_opcode); end
    endtask

    task automatic test_load();
        data_in = 4'd9;
        issue(OP_LOAD, 2'd3, 2'd3);
`ifdef ALU_SEQ_LOAD_EN
        vec++; if (dut.u_rf.r_reg[3] !== 4'd9) begin errs++; $display("FAIL load R3=%0d want 9", dut.u_rf.r_reg[3]); end
        vec++; if (z_flag !== 1'b0) begin errs++; $display("FAIL load_z z=%b want 0", z_flag); end
`else
        vec++; if (dut.u_rf.r_reg[3] !== 4'd7) begin errs++; $display("FAIL load_nop R3=%0d want 7", dut.u_rf.r_reg[3]); end
        vec++; if (z_flag !== 1'b0) begin errs++; $display("FAIL load_nop_z z=%b want 0", z_flag); end
`endif
        data_in = 4'd0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 4; i++) issue(OP_INC, 2'd0, 2'd0);
        vec++; if (dut.u_rf.r_reg[0] !== 4'd5) begin errs++; $display("FAIL inc_r0 R0=%0d want 5", dut.u_rf.r_reg[0]); end
        @(negedge clk);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        instr = {OP_INC, 2'd0, 2'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        vec++; if (dut.u_rf.r_reg[0] !== 4'd0 || busy !== 1'b0) begin errs++; $display("FAIL midrst_async R0=%0d busy=%b want 0 0", dut.u_rf.r_reg[0], busy); end
        vec++; if (M1 !== 4'd0 || alu_opcode !== 3'd0 || data_out !== 4'd0) begin errs++; $display("FAIL midrst_regs M1=%0d op=%0d dout=%0d want 0 0 0", M1, alu_opcode, data_out); end
        @(posedge clk); #1;
        vec++; if (dut.u_rf.r_reg[0] !== 4'd0 || data_out_valid !== 1'b0) begin errs++; $display("FAIL midrst_nowrite R0=%0d dov=%b want 0 0", dut.u_rf.r_reg[0], data_out_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vec++; if (instr_ready !== 1'b1 || busy !== 1'b0 || data_out_valid !== 1'b0) begin
            errs++; $display("FAIL midrst_idle ready=%b busy=%b dov=%b want 1 0 0", instr_ready, busy, data_out_valid); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_add_wrap();
        test_store();
        test_back_to_back();
        test_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 4, datapath and register width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr  input  7  instruction {opcode[6:4], xx[3:2], yy[1:0]}.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr_ready  output  1  sequencer can accept an instruction.
REQ-007 SHALL have port data_in  input  SIZE  load operand (LOAD option only).
REQ-008 SHALL have port M1  output  SIZE  ALU operand A = R[xx], registered.
REQ-009 SHALL have port M0  output  SIZE  ALU operand B = R[yy], registered.
REQ-010 SHALL have port alu_opcode  output  SIZE-1  ALU opcode, registered.
REQ-011 SHALL have port F4  input  SIZE  ALU result.
REQ-012 SHALL have port zero_flag  input  1  ALU zero indication.
REQ-013 SHALL have port data_out  output  SIZE  stored result.
REQ-014 SHALL have port data_out_valid  output  1  one-cycle pulse when data_out updates.
REQ-015 SHALL have port z_flag  output  1  registered zero flag of last result-producing instruction.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL hold four SIZE-bit registers R0..R3.
REQ-018 SHALL implement FSM IDLE -> READ -> WB -> IDLE, one cycle per state.
REQ-019 SHALL drive instr_ready high only in IDLE; accept occurs on instr_valid && instr_ready; instr_valid low in IDLE stays in IDLE.
REQ-020 SHALL, on accept, latch opcode/xx/yy and enter READ.
REQ-021 SHALL, in READ, register M1 <= R[xx], M0 <= R[yy], alu_opcode <= opcode, then enter WB.
REQ-022 SHALL, at end of WB, sample F4/zero_flag and act per opcode: 001 set, 010 inc, 011 dec, 110 add, 111 copy -> R[xx] <= F4; 101 store -> data_out <= F4, data_out_valid pulses in the following IDLE cycle; 000 and 100 (without option) -> no register/data_out change.
REQ-023 SHALL update z_flag from zero_flag on every opcode that writes R or data_out; otherwise hold.
REQ-024 SHALL keep M1/M0/alu_opcode stable from READ until the next READ.
REQ-025 SHALL give latency: accept edge t, result in R/data_out at edge t+2, instr_ready high from t+2; throughput one instruction per 3 cycles.
REQ-026 SHALL let xx == yy read and write the same register without hazard (read in READ, write in WB).
REQ-027 SHALL wrap arithmetic modulo 2^SIZE (ALU result taken as-is, no carry kept).
REQ-028 SHALL ignore instr_valid and instr while busy.

Reset
REQ-029 SHALL, on rst_n low at any time, immediately clear R0..R3, M1, M0, alu_opcode, data_out, data_out_valid, z_flag to 0 and FSM to IDLE, aborting any in-flight instruction with no write.
REQ-030 SHALL drive instr_ready high from the first edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with ALU_SEQ_LOAD_EN defined, treat opcode 100 as LOAD: R[xx] <= data_in at end of WB, z_flag <= (data_in == 0), ALU result ignored.
REQ-032 SHALL, without ALU_SEQ_LOAD_EN, treat opcode 100 as no-op and leave data_in unused.

Structure
REQ-033 SHALL place opcode constants (NOP, SET, INC, DEC, LOAD, STORE, ADD, COPY), field positions and the FSM state enum in package alu_seq_pkg.
REQ-034 SHALL implement R0..R3 in sub-module seq_reg_file (two async read ports, one sync write port, async active-low clear).

Verification (ALU model attached)
REQ-035 SHALL check: reset, SET R0 (0010000) -> R0=1 at t+2, z_flag=0, instr_ready high at t+2.
REQ-036 SHALL check: R1=15, ADD R1,R0 (R0=1) -> R1=0, z_flag=1.
REQ-037 SHALL check: R2=0, DEC R2 -> R2=15; then STORE R2 -> data_out=15, data_out_valid high exactly one cycle.
REQ-038 SHALL check: COPY R3,R1 (R1=7) -> R3=7, R1 unchanged; instr_valid held high back-to-back -> accepts exactly every 3 cycles.
REQ-039 SHALL check: rst_n low during WB of INC R0 (R0=5) -> R0=0, no data_out_valid, FSM IDLE.
REQ-040 SHALL check: opcode 100 with data_in=9 -> R[xx]=9 with ALU_SEQ_LOAD_EN, unchanged without.
